// File: rtl/sc_fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sc_fifo_arb_pkg
//  Brief    : Shared types and round-robin pick helper for sc_fifo_wr_arbiter
//  Revision : 1.0
// ============================================================================
package sc_fifo_arb_pkg;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } arb_state_t;

   // The pick helper works on a fixed-size vector; REQ_CNT may be at most 32.
   localparam int unsigned RR_MAX_REQ = 32;
   localparam int unsigned RR_IDX_W   = 5;

   typedef struct packed {
      logic                found;
      logic [RR_IDX_W-1:0] idx;
   } rr_pick_t;

   function automatic rr_pick_t rr_pick(
      input logic [RR_MAX_REQ-1:0] valid,
      input logic [RR_IDX_W-1:0]   ptr,
      input int unsigned           n
   );
      rr_pick_t    res;
      int unsigned cand;
      res = '0;
      for (int unsigned k = 1; k <= RR_MAX_REQ; k++) begin
         cand = (32'(ptr) + k) % n;
         if (!res.found && (k <= n) && valid[cand[RR_IDX_W-1:0]]) begin
            res.found = 1'b1;
            res.idx   = cand[RR_IDX_W-1:0];
         end
      end
      return res;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter_ptr.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter_ptr
//  Brief    : Round-robin pointer with combinational next-owner pick
//  Revision : 1.0
// ============================================================================
module rr_arbiter_ptr
   import sc_fifo_arb_pkg::*;
#(
   parameter int REQ_CNT = 4,
   parameter int PTR_W   = $clog2(REQ_CNT)
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [REQ_CNT-1:0] i_req_valid,
   input  logic               i_update,
   output logic               o_found,
   output logic [PTR_W-1:0]   o_idx,
   output logic [REQ_CNT-1:0] o_onehot
);

   logic [PTR_W-1:0]      r_ptr;
   logic [RR_MAX_REQ-1:0] w_valid_ext;
   logic [RR_IDX_W-1:0]   w_ptr_ext;
   rr_pick_t              w_pick;

   always_comb begin
      w_valid_ext                = '0;
      w_valid_ext[REQ_CNT-1:0]   = i_req_valid;
      w_ptr_ext                  = '0;
      w_ptr_ext[PTR_W-1:0]       = r_ptr;
      w_pick                     = rr_pick(w_valid_ext, w_ptr_ext, REQ_CNT);
   end

   assign o_found = w_pick.found;
   assign o_idx   = w_pick.idx[PTR_W-1:0];

   for (genvar k = 0; k < REQ_CNT; k++) begin : g_onehot
      assign o_onehot[k] = w_pick.found && (w_pick.idx == RR_IDX_W'(k));
   end

   // Reset to the last index so requester 0 is searched first.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ptr <= PTR_W'(REQ_CNT - 1);
      end else if (i_update) begin
         r_ptr <= o_idx;
      end
   end

endmodule
`default_nettype wire

// File: rtl/sc_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sc_fifo_wr_arbiter
//  Brief    : Burst-locked round-robin arbiter for a single-clock FIFO write port
//  Revision : 1.0
// ============================================================================
module sc_fifo_wr_arbiter
   import sc_fifo_arb_pkg::*;
#(
   parameter int REQ_CNT   = 4,
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 5,
   parameter int BURST_LEN = 4
) (
   input  logic                      clk_i,
   input  logic                      rst_n_i,
   input  logic [REQ_CNT-1:0]        req_valid_i,
   input  logic [REQ_CNT*DATA_W-1:0] req_data_i,
   output logic [REQ_CNT-1:0]        req_ready_o,
   output logic [REQ_CNT-1:0]        grant_o,
   output logic                      fifo_wr_en_o,
   output logic [DATA_W-1:0]         fifo_wr_data_o,
   input  logic [ADDR_W:0]           fifo_wr_usedw_i,
   input  logic                      fifo_wr_full_i
);

   localparam int PTR_W = $clog2(REQ_CNT);
   localparam int BC_W  = $clog2(BURST_LEN + 1);
   localparam logic [ADDR_W:0]  C_DEPTH     = (ADDR_W+1)'(2**ADDR_W);
   localparam logic [ADDR_W:0]  C_BURST     = (ADDR_W+1)'(BURST_LEN);
   localparam logic [BC_W-1:0]  C_LAST_BEAT = BC_W'(BURST_LEN - 1);

   arb_state_t          r_state;
   logic [REQ_CNT-1:0]  r_grant;
   logic [PTR_W-1:0]    r_owner;
   logic [BC_W-1:0]     r_beat_cnt;

   logic [ADDR_W:0]     w_free;
   logic                w_space_ok;
   logic                w_found;
   logic [PTR_W-1:0]    w_idx;
   logic [REQ_CNT-1:0]  w_onehot;
   logic                w_update;
   logic                w_owner_valid;
   logic                w_beat;
   logic [DATA_W-1:0]   w_data [REQ_CNT];

   for (genvar k = 0; k < REQ_CNT; k++) begin : g_data_slice
      assign w_data[k] = req_data_i[k*DATA_W +: DATA_W];
   end

   // A burst is only started when the whole burst is guaranteed to fit.
   assign w_free     = C_DEPTH - fifo_wr_usedw_i;
   assign w_space_ok = (w_free >= C_BURST);
   assign w_update   = (r_state == ST_IDLE) && w_found && w_space_ok;

   rr_arbiter_ptr #(
      .REQ_CNT (REQ_CNT),
      .PTR_W   (PTR_W)
   ) u_rr_ptr (
      .i_clk       (clk_i),
      .i_rst_n     (rst_n_i),
      .i_req_valid (req_valid_i),
      .i_update    (w_update),
      .o_found     (w_found),
      .o_idx       (w_idx),
      .o_onehot    (w_onehot)
   );

   assign grant_o        = r_grant;
   assign req_ready_o    = fifo_wr_full_i ? '0 : r_grant;
   assign w_owner_valid  = req_valid_i[r_owner];
   assign w_beat         = |(req_valid_i & req_ready_o);
   assign fifo_wr_en_o   = w_beat;
   assign fifo_wr_data_o = w_data[r_owner];

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state    <= ST_IDLE;
         r_grant    <= '0;
         r_owner    <= '0;
         r_beat_cnt <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_update) begin
                  r_grant    <= w_onehot;
                  r_owner    <= w_idx;
                  r_beat_cnt <= '0;
                  r_state    <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               if (!w_owner_valid) begin
                  r_grant    <= '0;
                  r_beat_cnt <= '0;
                  r_state    <= ST_IDLE;
               end else if (w_beat) begin
                  if (r_beat_cnt == C_LAST_BEAT) begin
                     r_grant    <= '0;
                     r_beat_cnt <= '0;
                     r_state    <= ST_IDLE;
                  end else begin
                     r_beat_cnt <= r_beat_cnt + 1'b1;
                  end
               end
            end
            default: begin
               r_grant <= '0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sc_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sc_fifo_wr_arbiter
//  Brief    : Self-checking bench for sc_fifo_wr_arbiter with a queue FIFO model
//  Revision : 1.0
// ============================================================================
module tb_sc_fifo_wr_arbiter;

   localparam int N     = 4;
   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int BL    = 4;
   localparam int DEPTH = 32;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    valid;
   logic [N*DW-1:0] data;
   logic [N-1:0]    ready;
   logic [N-1:0]    grant;
   logic            wr_en;
   logic [DW-1:0]   wr_data;
   logic [AW:0]     usedw;
   logic            full;
   logic            rd;

   always #5 clk = ~clk;

   sc_fifo_wr_arbiter #(
      .REQ_CNT(N), .DATA_W(DW), .ADDR_W(AW), .BURST_LEN(BL)
   ) dut (
      .clk_i           (clk),
      .rst_n_i         (rst_n),
      .req_valid_i     (valid),
      .req_data_i      (data),
      .req_ready_o     (ready),
      .grant_o         (grant),
      .fifo_wr_en_o    (wr_en),
      .fifo_wr_data_o  (wr_data),
      .fifo_wr_usedw_i (usedw),
      .fifo_wr_full_i  (full)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic [DW-1:0] fq[$];
   bit            model_en;
   bit            sb_en;
   int unsigned   seq[N];
   int unsigned   rd_seq[N];

   logic          s_wr_en;
   logic [DW-1:0] s_wr_data;
   logic [N-1:0]  s_grant;
   logic [N-1:0]  s_ready;

   typedef struct {
      logic [N-1:0] valid;
      logic [AW:0]  usedw;
      logic         full;
      logic [N-1:0] exp_grant;
      logic [N-1:0] exp_ready;
      logic         exp_wr;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] word(input int k, input int unsigned s);
      return {8'(k), 24'(s)};
   endfunction

   task automatic drive_data();
      for (int k = 0; k < N; k++) data[k*DW +: DW] = word(k, seq[k]);
   endtask

   // One clock: sample outputs before the edge, then update the FIFO model after it.
   task automatic tick();
      logic [DW-1:0] w;
      bit            pop_ok;
      int            pre_size;
      #1;
      s_wr_en   = wr_en;
      s_wr_data = wr_data;
      s_grant   = grant;
      s_ready   = ready;
      pre_size  = fq.size();
      pop_ok    = rd && (pre_size > 0);
      @(posedge clk);
      #1;
      if (model_en) begin
         if (s_wr_en) begin
            check("no_overflow", 64'(pre_size < DEPTH), 64'd1);
         end
         if (pop_ok) begin
            w = fq.pop_front();
            if (sb_en) begin
               check("rd_src", 64'(w[31:24] < N), 64'd1);
               if (w[31:24] < N) begin
                  check($sformatf("rd_order_src%0d", w[31:24]), 64'(w[23:0]),
                        64'(24'(rd_seq[w[31:24]])));
                  rd_seq[w[31:24]]++;
               end
            end
         end
         if (s_wr_en && fq.size() < DEPTH) fq.push_back(s_wr_data);
         usedw = (AW+1)'(fq.size());
         full  = (fq.size() == DEPTH);
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      valid    = '0;
      rd       = 1'b0;
      model_en = 1'b0;
      sb_en    = 1'b0;
      fq.delete();
      usedw    = '0;
      full     = 1'b0;
      for (int k = 0; k < N; k++) begin
         seq[k]    = 0;
         rd_seq[k] = 0;
      end
      drive_data();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic drain(input string tag);
      valid = '0;
      rd    = 1'b1;
      for (int i = 0; i < 80 && fq.size() > 0; i++) tick();
      rd = 1'b0;
      check({tag, "_drained"}, 64'(fq.size()), 64'd0);
      for (int k = 0; k < N; k++)
         check($sformatf("%s_count_src%0d", tag, k), 64'(rd_seq[k]), 64'(seq[k]));
   endtask

   initial begin
      int            sent;
      int            exp_wr1[14];
      int            wr_owner[$];
      int            o;
      int            m_owner;
      int            m_last;
      int            m_cnt;
      logic [N-1:0]  exp_g;
      logic          exp_wr;
      logic [AW:0]   pre_usedw;

      rst_n = 1'b0;
      valid = '0;
      data  = '0;
      usedw = '0;
      full  = 1'b0;
      rd    = 1'b0;

      // ---------------- reset state ----------------
      #2;
      valid = '1;
      #1;
      check("rst_grant", 64'(grant), 64'd0);
      check("rst_ready", 64'(ready), 64'd0);
      check("rst_wr_en", 64'(wr_en), 64'd0);

      // ---------------- table-driven vectors ----------------
      vecs[0] = '{4'b0100, 6'd29, 1'b0, 4'b0000, 4'b0000, 1'b0};
      vecs[1] = '{4'b0100, 6'd28, 1'b0, 4'b0100, 4'b0100, 1'b1};
      vecs[2] = '{4'b0001, 6'd0,  1'b0, 4'b0001, 4'b0001, 1'b1};
      vecs[3] = '{4'b1010, 6'd32, 1'b0, 4'b0000, 4'b0000, 1'b0};
      vecs[4] = '{4'b1010, 6'd0,  1'b0, 4'b0010, 4'b0010, 1'b1};
      vecs[5] = '{4'b0000, 6'd0,  1'b0, 4'b0000, 4'b0000, 1'b0};
      vecs[6] = '{4'b1000, 6'd31, 1'b0, 4'b0000, 4'b0000, 1'b0};
      vecs[7] = '{4'b1000, 6'd28, 1'b1, 4'b1000, 4'b0000, 1'b0};
      vecs[8] = '{4'b1111, 6'd10, 1'b0, 4'b0001, 4'b0001, 1'b1};
      vecs[9] = '{4'b0110, 6'd27, 1'b1, 4'b0010, 4'b0000, 1'b0};
      for (int i = 0; i < 10; i++) begin
         do_reset();
         valid = vecs[i].valid;
         usedw = vecs[i].usedw;
         full  = 1'b0;
         tick();
         full = vecs[i].full;
         tick();
         check($sformatf("vec%0d_grant", i), 64'(s_grant), 64'(vecs[i].exp_grant));
         check($sformatf("vec%0d_ready", i), 64'(s_ready), 64'(vecs[i].exp_ready));
         check($sformatf("vec%0d_wr_en", i), 64'(s_wr_en), 64'(vecs[i].exp_wr));
      end

      // ---------------- single requester, 10 words -> 4,4,2 ----------------
      do_reset();
      model_en = 1'b1;
      exp_wr1  = '{0,1,1,1,1,0,1,1,1,1,0,1,1,0};
      sent     = 0;
      for (int c = 0; c < 14; c++) begin
         valid[0]        = (sent < 10);
         data[0 +: DW]   = 32'hA000_0000 + 32'(sent);
         tick();
         check($sformatf("t1_wr_en_c%0d", c), 64'(s_wr_en), 64'(exp_wr1[c]));
         if (s_wr_en) sent++;
      end
      valid = '0;
      check("t1_usedw", 64'(usedw), 64'd10);
      for (int i = 0; i < 10 && i < fq.size(); i++)
         check($sformatf("t1_word%0d", i), 64'(fq[i]), 64'(32'hA000_0000 + 32'(i)));

      // ---------------- all requesters busy ----------------
      do_reset();
      model_en = 1'b1;
      sb_en    = 1'b1;
      rd       = 1'b1;
      valid    = '1;
      for (int c = 0; c < 40; c++) begin
         drive_data();
         tick();
         if (s_wr_en) begin
            o = 0;
            for (int k = 0; k < N; k++) if (s_grant[k]) o = k;
            check("t2_data", 64'(s_wr_data), 64'(word(o, seq[o])));
            wr_owner.push_back(o);
            seq[o]++;
         end
      end
      check("t2_enough_writes", 64'(wr_owner.size() >= 16), 64'd1);
      for (int i = 0; i < 16 && i < wr_owner.size(); i++)
         check($sformatf("t2_owner%0d", i), 64'(wr_owner[i]), 64'((i / 4) % 4));
      drain("t2");

      // ---------------- reservation: free=3 blocks, free=4 grants ----------------
      do_reset();
      model_en = 1'b1;
      for (int i = 0; i < 29; i++) fq.push_back(32'hFF00_0000 + 32'(i));
      usedw = 6'd29;
      valid = 4'b0100;
      for (int c = 0; c < 3; c++) begin
         tick();
         check("t3_no_grant", 64'(s_grant), 64'd0);
         check("t3_no_wr", 64'(s_wr_en), 64'd0);
      end
      rd = 1'b1;
      tick();
      check("t3_read_cycle_grant", 64'(s_grant), 64'd0);
      rd = 1'b0;
      tick();
      check("t3_arb_cycle_grant", 64'(s_grant), 64'd0);
      tick();
      check("t3_grant2", 64'(s_grant), 64'b0100);
      check("t3_wr", 64'(s_wr_en), 64'd1);
      valid = '0;
      tick();

      // ---------------- early release and fairness ----------------
      do_reset();
      model_en = 1'b1;
      valid    = 4'b0010;
      tick();
      check("t4_bubble", 64'(s_grant), 64'd0);
      tick();
      check("t4_grant1", 64'(s_grant), 64'b0010);
      check("t4_beat1", 64'(s_wr_en), 64'd1);
      tick();
      check("t4_beat2", 64'(s_wr_en), 64'd1);
      valid = 4'b0000;
      tick();
      check("t4_drop_held", 64'(s_grant), 64'b0010);
      check("t4_drop_no_wr", 64'(s_wr_en), 64'd0);
      valid = 4'b0110;
      tick();
      check("t4_released", 64'(s_grant), 64'd0);
      tick();
      check("t4_next_is_2", 64'(s_grant), 64'b0100);

      // ---------------- reset mid-burst ----------------
      do_reset();
      model_en = 1'b1;
      valid    = 4'b1111;
      tick();
      tick();
      check("t5_grant0", 64'(s_grant), 64'b0001);
      rst_n = 1'b0;
      #1;
      check("t5_rst_grant", 64'(grant), 64'd0);
      check("t5_rst_ready", 64'(ready), 64'd0);
      check("t5_rst_wr_en", 64'(wr_en), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      fq.delete();
      usedw = '0;
      full  = 1'b0;
      valid = 4'b1010;
      tick();
      check("t5_bubble", 64'(s_grant), 64'd0);
      tick();
      check("t5_first_after_rst", 64'(s_grant), 64'b0010);

      // ---------------- random traffic vs reference model ----------------
      do_reset();
      model_en = 1'b1;
      sb_en    = 1'b1;
      m_owner  = -1;
      m_last   = N - 1;
      m_cnt    = 0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         for (int k = 0; k < N; k++) valid[k] = ($urandom_range(0, 3) != 0);
         rd = ($urandom_range(0, 2) == 0);
         drive_data();
         pre_usedw = usedw;
         exp_g  = (m_owner >= 0) ? N'(1 << m_owner) : '0;
         exp_wr = (m_owner >= 0) && valid[m_owner] && !full;
         tick();
         check("rnd_grant", 64'(s_grant), 64'(exp_g));
         check("rnd_wr_en", 64'(s_wr_en), 64'(exp_wr));
         if (exp_wr) begin
            check("rnd_data", 64'(s_wr_data), 64'(word(m_owner, seq[m_owner])));
            seq[m_owner]++;
         end
         if (m_owner < 0) begin
            if (valid != '0 && (DEPTH - int'(pre_usedw)) >= BL) begin
               for (int j = 1; j <= N; j++) begin
                  if (m_owner < 0 && valid[(m_last + j) % N]) begin
                     m_owner = (m_last + j) % N;
                     m_last  = m_owner;
                     m_cnt   = 0;
                  end
               end
            end
         end else if (!valid[m_owner]) begin
            m_owner = -1;
         end else if (exp_wr) begin
            m_cnt++;
            if (m_cnt == BL) m_owner = -1;
         end
      end
      drain("rnd");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
